// File: rtl/button_conditioner.sv
// button_conditioner: synchronises a raw push-button and debounces it with a
// stability counter. It emits one-cycle press/release pulses for the counter
// stage downstream.
// Optional auto-repeat: define BUTTON_CONDITIONER_AUTOREPEAT_EN to re-fire
// press (with rpt=1) while the button is held.
// The release pulse port is named release_pulse because `release` is a
// reserved word in SystemVerilog.
module button_conditioner #(
    parameter int STABLE_CYCLES = 100000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic rpt
);

    localparam int CW = $clog2(STABLE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            s1;
    logic            s;
    logic [CW-1:0]   cnt;
    logic            at_thresh;
    logic            press_acc;
    logic            release_nxt;
    logic            level_nxt;
    logic            rpt_fire;

    // A disagreement with level that has lasted the full window is accepted.
    assign at_thresh = (s != level) && (cnt == CW'(STABLE_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= button;
            s  <= s1;
        end
    end

    // Stability counter: any agreement with level discards accumulated progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if ((s == level) || at_thresh) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Next-state and pulse decode for the debounce FSM.
    always_comb begin
        state_nxt   = state;
        press_acc   = 1'b0;
        release_nxt = 1'b0;
        level_nxt   = level;
        case (state)
            RELEASED: begin
                if (s) begin
                    state_nxt = PRESS_PEND;
                end else begin
                    state_nxt = RELEASED;
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_nxt = RELEASED;
                end else if (at_thresh) begin
                    state_nxt = PRESSED;
                    press_acc = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    state_nxt = PRESS_PEND;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = RELEASE_PEND;
                end else begin
                    state_nxt = PRESSED;
                end
            end
            RELEASE_PEND: begin
                if (s) begin
                    state_nxt = PRESSED;
                end else if (at_thresh) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    state_nxt = RELEASE_PEND;
                end
            end
            default: begin
                state_nxt = RELEASED;
                level_nxt = 1'b0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RELEASED;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            rpt           <= 1'b0;
        end else begin
            state         <= state_nxt;
            level         <= level_nxt;
            press         <= press_acc | rpt_fire;
            release_pulse <= release_nxt;
            rpt           <= rpt_fire;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          first_pend;
    logic [RW-1:0] rlimit;

    assign rlimit   = first_pend ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rpt_fire = (state == PRESSED) && (rcnt == rlimit);

    // Repeat counter: runs only while pressed, holds across a release bounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt       <= '0;
            first_pend <= 1'b1;
        end else if (press_acc || (state == RELEASED)) begin
            rcnt       <= '0;
            first_pend <= 1'b1;
        end else if (rpt_fire) begin
            rcnt       <= '0;
            first_pend <= 1'b0;
        end else if (state == PRESSED) begin
            rcnt       <= rcnt + RW'(1);
            first_pend <= first_pend;
        end else begin
            rcnt       <= rcnt;
            first_pend <= first_pend;
        end
    end
`else
    logic unused_rpt_cfg;

    assign rpt_fire       = 1'b0;
    assign unused_rpt_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an event scoreboard: expected
// press/release pulses are queued when the button is driven and popped when
// the DUT pulses. Honours BUTTON_CONDITIONER_AUTOREPEAT_EN.
module tb_button_conditioner;

    localparam int SC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic reset;
    logic button;
    logic level;
    logic press;
    logic release_pulse;
    logic rpt;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_rel;
        int at;
        bit rpt;
    } ev_t;

    ev_t exp_q[$];

    button_conditioner #(
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button       (button),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .rpt          (rpt)
    );

    always #5 clk = ~clk;

    // Count rising edges; an output seen at a negedge belongs to edge cyc.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic expect_ev(input bit is_rel, input int at, input bit r);
        ev_t e;
        e.is_rel = is_rel;
        e.at     = at;
        e.rpt    = r;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        ev_t e;
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            chk("missed_event_at", -1, e.at);
        end
        if (press || release_pulse || rpt) begin
            chk("event_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.at);
                chk("event_press", int'(press), int'(!e.is_rel));
                chk("event_release", int'(release_pulse), int'(e.is_rel));
                chk("event_rpt", int'(rpt), int'(e.rpt));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k;
        bit pat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        reset  = 1'b1;
        button = 1'b0;
        ticks(3);
        chk("reset_level", int'(level), 0);
        chk("reset_press", int'(press), 0);
        chk("reset_release", int'(release_pulse), 0);
        chk("reset_rpt", int'(rpt), 0);
        reset = 1'b0;
        ticks(5);

        // Clean press held 50 cycles, then clean release.
        k      = cyc;
        button = 1'b1;
        expect_ev(1'b0, k + 6, 1'b0);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        for (int r = 0; r < 4; r++) expect_ev(1'b0, k + 6 + RD + r * RP, 1'b1);
`endif
        ticks(5);
        chk("press_level_pre", int'(level), 0);
        tick();
        chk("press_level_post", int'(level), 1);
        ticks(44);
        button = 1'b0;
        expect_ev(1'b1, k + 56, 1'b0);
        ticks(5);
        chk("release_level_pre", int'(level), 1);
        tick();
        chk("release_level_post", int'(level), 0);
        ticks(10);

        // Bouncing press, a short glitch while pressed, then release.
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            button = pat[i];
            tick();
        end
        expect_ev(1'b0, k + 11, 1'b0);
        ticks(3);
        button = 1'b0;
        ticks(2);
        button = 1'b1;
        ticks(3);
        chk("glitch_level_held", int'(level), 1);
        button = 1'b0;
        expect_ev(1'b1, k + 24, 1'b0);
        ticks(6);
        chk("bounce_release_level", int'(level), 0);
        ticks(8);

        // Reset during PRESS_PEND with cnt=2, button kept high.
        k      = cyc;
        button = 1'b1;
        ticks(4);
        reset = 1'b1;
        tick();
        chk("midpend_level", int'(level), 0);
        chk("midpend_press", int'(press), 0);
        chk("midpend_release", int'(release_pulse), 0);
        chk("midpend_rpt", int'(rpt), 0);
        reset = 1'b0;
        expect_ev(1'b0, k + 11, 1'b0);
        ticks(6);
        chk("midpend_requal_level", int'(level), 1);
        ticks(4);
        button = 1'b0;
        expect_ev(1'b1, k + 21, 1'b0);
        ticks(8);

        // 60-cycle hold: repeats only with auto-repeat built in.
        k      = cyc;
        button = 1'b1;
        expect_ev(1'b0, k + 6, 1'b0);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        for (int r = 0; r < 5; r++) expect_ev(1'b0, k + 6 + RD + r * RP, 1'b1);
`endif
        ticks(60);
        button = 1'b0;
        expect_ev(1'b1, k + 66, 1'b0);
        ticks(10);
        chk("hold_final_level", int'(level), 0);

        ticks(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
